// File: rtl/seg7_to_bin_if.sv
// seg7_to_bin_if
//   Handshake and data bundle for the 7-segment to binary decoder.
//   seg_in/in_valid/in_ready : input word (NUM_DIGITS segment patterns, MSD on top)
//   bin_out/bcd_out/err/ovf  : decoded result
//   out_valid/out_ready      : result handshake
//   master = word producer / result consumer, slave = decoder.
interface seg7_to_bin_if #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 8
);
  logic [7*NUM_DIGITS-1:0] seg_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [OUT_W-1:0]        bin_out;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    err;
  logic                    ovf;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output seg_in, in_valid, out_ready,
    input  in_ready, bin_out, bcd_out, err, ovf, out_valid
  );

  modport slave (
    input  seg_in, in_valid, out_ready,
    output in_ready, bin_out, bcd_out, err, ovf, out_valid
  );
endinterface

// File: rtl/seg7_to_bin.sv
// seg7_to_bin
//   Decodes NUM_DIGITS 7-segment patterns ({a..g}, a = bit 6) into BCD digits
//   and accumulates them MSD-first into a saturating OUT_W-bit binary value,
//   one digit per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : seg7_to_bin_if.slave (input word handshake, result handshake)
//   Flow: IDLE (accept word) -> ACC (NUM_DIGITS cycles) -> DONE (hold result
//   until consumed) -> IDLE. No overlap between input and output.
module seg7_to_bin #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_to_bin_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ACC_W = OUT_W + 4;
  // acc*10 + 9 never exceeds 10*(2^OUT_W-1)+9, which fits in OUT_W+4 bits;
  // the extra margin keeps the compare free of wrap-around.
  localparam int EXT_W = OUT_W + 8;
  localparam logic [ACC_W-1:0] SAT = {{4{1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    err_reg;
  logic                    ovf_reg;
  logic [OUT_W-1:0]        bin_reg;
  logic [4*NUM_DIGITS-1:0] bcd_reg;

  // Exact-match decode; returns {legal, digit}. Illegal patterns read as 0.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h7E:   decode = {1'b1, 4'd0};
      7'h30:   decode = {1'b1, 4'd1};
      7'h6D:   decode = {1'b1, 4'd2};
      7'h79:   decode = {1'b1, 4'd3};
      7'h33:   decode = {1'b1, 4'd4};
      7'h5B:   decode = {1'b1, 4'd5};
      7'h5F:   decode = {1'b1, 4'd6};
      7'h70:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h7B:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  // Per-position decoders; position 0 is the most significant digit.
  logic [3:0] digit_dec [NUM_DIGITS];
  logic       legal_dec [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      assign {legal_dec[gi], digit_dec[gi]} = decode(seg_reg[7*(NUM_DIGITS-gi)-1 -: 7]);
    end
  endgenerate

  logic [3:0]              cur_digit;
  logic                    cur_legal;
  logic [EXT_W-1:0]        acc_ext;
  logic                    ovf_step;
  logic [ACC_W-1:0]        acc_step;
  logic                    err_step;
  logic                    ovf_flag_step;
  logic                    last_digit;
  logic [4*NUM_DIGITS-1:0] bcd_step;

  always_comb begin
    cur_digit = 4'd0;
    cur_legal = 1'b0;
    bcd_step  = bcd_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_digit = digit_dec[i];
        cur_legal = legal_dec[i];
        bcd_step[4*(NUM_DIGITS-1-i) +: 4] = digit_dec[i];
      end
    end
    acc_ext       = EXT_W'(acc_reg) * EXT_W'(10) + EXT_W'(cur_digit);
    ovf_step      = acc_ext > EXT_W'(SAT);
    // Clamping at every step keeps later digits from re-growing past the limit.
    acc_step      = ovf_step ? SAT : acc_ext[ACC_W-1:0];
    err_step      = err_reg | ~cur_legal;
    ovf_flag_step = ovf_reg | ovf_step;
    last_digit    = (idx_reg == IDX_W'(NUM_DIGITS-1));
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = ACC;
      ACC:     if (last_digit) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath. Result registers only change during ACC, so they hold through
  // DONE (backpressure) and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= '0;
      acc_reg <= '0;
      idx_reg <= '0;
      err_reg <= 1'b0;
      ovf_reg <= 1'b0;
      bin_reg <= '0;
      bcd_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            seg_reg <= bus.seg_in;
            acc_reg <= '0;
            idx_reg <= '0;
            err_reg <= 1'b0;
            ovf_reg <= 1'b0;
          end
        end
        ACC: begin
          acc_reg <= acc_step;
          err_reg <= err_step;
          ovf_reg <= ovf_flag_step;
          bcd_reg <= bcd_step;
          idx_reg <= idx_reg + IDX_W'(1);
          if (last_digit) begin
            bin_reg <= err_step ? '0 : acc_step[OUT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.bin_out   = bin_reg;
  assign bus.bcd_out   = bcd_reg;
  assign bus.err       = err_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_seg7_to_bin.sv
module tb_seg7_to_bin;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_to_bin_if #(.NUM_DIGITS(3), .OUT_W(8)) bus ();

  seg7_to_bin #(.NUM_DIGITS(3), .OUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [20:0] seg;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: code = 7'h7E; 1: code = 7'h30; 2: code = 7'h6D; 3: code = 7'h79;
      4: code = 7'h33; 5: code = 7'h5B; 6: code = 7'h5F; 7: code = 7'h70;
      8: code = 7'h7F; default: code = 7'h7B;
    endcase
  endfunction

  // Accept one word and count edges until out_valid (bounded at 20).
  task automatic accept_and_wait(input logic [20:0] seg, output int lat);
    bus.seg_in   = seg;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d [3];
    int acc;
    logic mod_ovf;
    logic [20:0] words [10];
    logic [7:0]  exp_bin [10];
    logic [11:0] exp_bcd [10];
    logic        exp_ovf [10];
    int t_prev, t_now;

    vecs[0]  = '{{7'h30, 7'h6D, 7'h79}, 8'd123, 12'h123, 1'b0, 1'b0};
    vecs[1]  = '{{7'h6D, 7'h5B, 7'h5B}, 8'd255, 12'h255, 1'b0, 1'b0};
    vecs[2]  = '{{7'h6D, 7'h5B, 7'h5F}, 8'd255, 12'h256, 1'b0, 1'b1};
    vecs[3]  = '{{7'h7B, 7'h7B, 7'h7B}, 8'd255, 12'h999, 1'b0, 1'b1};
    vecs[4]  = '{{7'h30, 7'h00, 7'h79}, 8'd0,   12'h103, 1'b1, 1'b0};
    vecs[5]  = '{{7'h30, 7'h31, 7'h79}, 8'd0,   12'h103, 1'b1, 1'b0};
    vecs[6]  = '{{7'h7E, 7'h7E, 7'h7E}, 8'd0,   12'h000, 1'b0, 1'b0};
    vecs[7]  = '{{7'h33, 7'h5F, 7'h70}, 8'd255, 12'h467, 1'b0, 1'b1};
    vecs[8]  = '{{7'h7E, 7'h7F, 7'h5B}, 8'd85,  12'h085, 1'b0, 1'b0};
    vecs[9]  = '{{7'h7E, 7'h7E, 7'h33}, 8'd4,   12'h004, 1'b0, 1'b0};
    vecs[10] = '{{7'h7B, 7'h7B, 7'h00}, 8'd0,   12'h990, 1'b1, 1'b1};

    // Reset state
    rst_n = 1'b0;
    bus.seg_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_bin", 32'(bus.bin_out), 0);
    check("rst_bcd", 32'(bus.bcd_out), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      bus.out_ready = 1'b1;
      check("idle_in_ready", 32'(bus.in_ready), 1);
      accept_and_wait(vecs[i].seg, lat);
      $display("vec %0d seg=%h bin=%0d bcd=%h err=%0b ovf=%0b lat=%0d",
               i, vecs[i].seg, bus.bin_out, bus.bcd_out, bus.err, bus.ovf, lat);
      check("latency", 32'(lat), 3);
      check("bin_out", 32'(bus.bin_out), 32'(vecs[i].bin));
      check("bcd_out", 32'(bus.bcd_out), 32'(vecs[i].bcd));
      check("err", 32'(bus.err), 32'(vecs[i].err));
      check("ovf", 32'(bus.ovf), 32'(vecs[i].ovf));
      check("done_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      check("consumed_out_valid", 32'(bus.out_valid), 0);
    end

    // Backpressure: hold for 6 cycles, new in_valid ignored
    bus.out_ready = 1'b0;
    accept_and_wait({7'h30, 7'h6D, 7'h79}, lat);
    check("bp_latency", 32'(lat), 3);
    bus.seg_in = {7'h7B, 7'h7B, 7'h7B};
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      $display("hold %0d out_valid=%0b bin=%0d in_ready=%0b", k, bus.out_valid, bus.bin_out, bus.in_ready);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_bin", 32'(bus.bin_out), 123);
      check("bp_bcd", 32'(bus.bcd_out), 32'h123);
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("idle_hold_bin", 32'(bus.bin_out), 123);
    @(posedge clk); #1;
    check("ignored_word_still_idle", 32'(bus.in_ready), 1);

    // Reset during the second ACC cycle
    bus.seg_in = {7'h7B, 7'h7B, 7'h7B};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("midreset bin=%0d bcd=%h in_ready=%0b", bus.bin_out, bus.bcd_out, bus.in_ready);
    check("mr_bin", 32'(bus.bin_out), 0);
    check("mr_bcd", 32'(bus.bcd_out), 0);
    check("mr_err", 32'(bus.err), 0);
    check("mr_ovf", 32'(bus.ovf), 0);
    check("mr_out_valid", 32'(bus.out_valid), 0);
    check("mr_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    accept_and_wait({7'h7E, 7'h7E, 7'h33}, lat);
    $display("post-reset bin=%0d lat=%0d", bus.bin_out, lat);
    check("mr_next_latency", 32'(lat), 3);
    check("mr_next_bin", 32'(bus.bin_out), 4);
    check("mr_next_err", 32'(bus.err), 0);
    @(posedge clk); #1;

    // Back-to-back random legal words, in_valid held high
    for (int k = 0; k < 10; k++) begin
      acc = 0;
      mod_ovf = 1'b0;
      for (int j = 0; j < 3; j++) begin
        d[j] = int'($urandom_range(0, 9));
        acc = acc * 10 + d[j];
        if (acc > 255) begin
          acc = 255;
          mod_ovf = 1'b1;
        end
      end
      words[k]   = {code(d[0]), code(d[1]), code(d[2])};
      exp_bin[k] = 8'(acc);
      exp_bcd[k] = {4'(d[0]), 4'(d[1]), 4'(d[2])};
      exp_ovf[k] = mod_ovf;
    end
    bus.out_ready = 1'b1;
    bus.seg_in = words[0];
    bus.in_valid = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k < 9) bus.seg_in = words[k+1];
      else bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      t_now = cyc;
      $display("b2b %0d seg=%h bin=%0d bcd=%h ovf=%0b", k, words[k], bus.bin_out, bus.bcd_out, bus.ovf);
      check("b2b_latency", 32'(lat), 3);
      check("b2b_bin", 32'(bus.bin_out), 32'(exp_bin[k]));
      check("b2b_bcd", 32'(bus.bcd_out), 32'(exp_bcd[k]));
      check("b2b_ovf", 32'(bus.ovf), 32'(exp_ovf[k]));
      check("b2b_err", 32'(bus.err), 0);
      if (k > 0) check("b2b_period", 32'(t_now - t_prev), 5);
      t_prev = t_now;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
